multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl_aludec.sv | 32 +++
 rtl/multicycle_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation groups, mux selects and ALU control codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCHEX = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JEX      = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; slave is the controller side.
interface multicycle_ctrl_if;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        iord;
    logic        memwrite;
    logic        irwrite;
    logic        regdst;
    logic        memtoreg;
    logic        regwrite;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic        pcen;
    logic [3:0]  alucontrol;
    logic        instr_done;
    logic [31:0] instr_count;

    modport slave (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, instr_count
    );

    modport master (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, instr_done, instr_count
    );

endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: maps the FSM's aluop group and the funct field to an ALU
// operation; unrecognised funct codes produce the inert ALU_NONE code.
module multicycle_ctrl_aludec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct_i,
    input  aluop_e     aluop_i,
    output logic [3:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_NONE;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALU_ADD;
                    FUNCT_SUB: alucontrol_o = ALU_SUB;
                    FUNCT_AND: alucontrol_o = ALU_AND;
                    FUNCT_OR:  alucontrol_o = ALU_OR;
                    FUNCT_XOR: alucontrol_o = ALU_XOR;
                    FUNCT_NOR: alucontrol_o = ALU_NOR;
                    FUNCT_SLT: alucontrol_o = ALU_SLT;
                    default:   alucontrol_o = ALU_NONE;
                endcase
            end
            default: alucontrol_o = ALU_NONE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states and retirement counter.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;

    logic        mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic        pcwrite, branch, bne_branch, retire;
    aluop_e      aluop;
    logic [3:0]  alucontrol;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // While reset is high every control stays at its default, so an
    // interrupted instruction can neither write nor retire.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne_branch = 1'b0;
        retire     = 1'b0;
        aluop      = ALUOP_ADD;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alusrcb = SRCB_IMMSH2;
                    case (bus.op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_RTYPEEX;
                        OP_BEQ:       state_d = S_BRANCHEX;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_BNE_EN
                        OP_BNE:       state_d = S_BRANCHEX;
`endif
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (bus.mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    if (bus.mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                    state_d = S_RTYPEWB;
                end
                S_RTYPEWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCHEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = PCSRC_ALUOUT;
`ifdef MULTICYCLE_BNE_EN
                    bne_branch = (bus.op == OP_BNE);
`endif
                    branch  = ~bne_branch;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JEX: begin
                    pcsrc   = PCSRC_JUMP;
                    pcwrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        count_d = retire ? (count_q + 32'd1) : count_q;
    end

    multicycle_ctrl_aludec u_aludec (
        .funct_i      (bus.funct),
        .aluop_i      (aluop),
        .alucontrol_o (alucontrol)
    );

    assign bus.mem_req     = mem_req;
    assign bus.iord        = iord;
    assign bus.memwrite    = memwrite;
    assign bus.irwrite     = irwrite;
    assign bus.regdst      = regdst;
    assign bus.memtoreg    = memtoreg;
    assign bus.regwrite    = regwrite;
    assign bus.alusrca     = alusrca;
    assign bus.alusrcb     = alusrcb;
    assign bus.pcsrc       = pcsrc;
    assign bus.pcen        = pcwrite | (branch & bus.zero) | (bne_branch & ~bus.zero);
    assign bus.alucontrol  = alucontrol;
    assign bus.instr_done  = retire;
    assign bus.instr_count = count_q;

endmodule
